// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between icache refill and
// dcache refill/writeback. One line transfer in flight at a time.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise dcache wins ties (fixed priority).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic              dc_wdata_valid,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    output logic              mem_wdata_valid,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              owner_q, owner_d;   // 1 = dcache owns the transfer
    logic              grant_dc, grant_ic;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;     // 1 = dcache was granted last
`endif

    // Winner selection among pending requests (only acted on in IDLE)
    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (ic_req_valid && dc_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_dc = ~last_q;
`else
            grant_dc = 1'b1;
`endif
            grant_ic = ~grant_dc;
        end else begin
            grant_dc = dc_req_valid;
            grant_ic = ic_req_valid;
        end
    end

    // Data buses are pure pass-through; qualifiers below gate their meaning
    assign resp_data    = mem_resp_data;
    assign mem_wdata    = dc_wdata;
    assign mem_req_addr = addr_q;
    assign mem_req_rw   = rw_q;

    // Next-state and handshake steering; all strobes forced low while in reset
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        rw_d            = rw_q;
        owner_d         = owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d          = last_q;
`endif
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        dc_resp_valid   = 1'b0;
        dc_wdata_ready  = 1'b0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;

        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    ic_req_ready = grant_ic;
                    dc_req_ready = grant_dc;
                    if (grant_ic || grant_dc) begin
                        addr_d  = grant_dc ? dc_req_addr : ic_req_addr;
                        rw_d    = grant_dc & dc_req_rw;
                        owner_d = grant_dc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d  = grant_dc;
`endif
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        cnt_d   = '0;
                        state_d = rw_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    mem_wdata_valid = dc_wdata_valid;
                    dc_wdata_ready  = mem_wdata_ready;
                    if (dc_wdata_valid && mem_wdata_ready) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            state_d = IDLE;
                        end
                    end
                end
                RDATA: begin
                    ic_resp_valid = mem_resp_valid & ~owner_q;
                    dc_resp_valid = mem_resp_valid & owner_q;
                    if (mem_resp_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and transaction registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            owner_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            owner_q <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters).
// Tie-break expectations follow MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic        dc_req_valid;
    logic        dc_req_rw;
    logic [31:0] dc_req_addr;
    logic        dc_req_ready;
    logic        dc_wdata_valid;
    logic [31:0] dc_wdata;
    logic        dc_wdata_ready;
    logic        dc_resp_valid;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_wdata_valid;
    logic [31:0] mem_wdata;
    logic        mem_wdata_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .ic_req_valid    (ic_req_valid),
        .ic_req_addr     (ic_req_addr),
        .ic_req_ready    (ic_req_ready),
        .ic_resp_valid   (ic_resp_valid),
        .dc_req_valid    (dc_req_valid),
        .dc_req_rw       (dc_req_rw),
        .dc_req_addr     (dc_req_addr),
        .dc_req_ready    (dc_req_ready),
        .dc_wdata_valid  (dc_wdata_valid),
        .dc_wdata        (dc_wdata),
        .dc_wdata_ready  (dc_wdata_ready),
        .dc_resp_valid   (dc_resp_valid),
        .resp_data       (resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata       (mem_wdata),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe output low
    task automatic check_quiet(input string tag);
        check({tag, "_ic_req_ready"},    32'(ic_req_ready),    32'd0);
        check({tag, "_dc_req_ready"},    32'(dc_req_ready),    32'd0);
        check({tag, "_ic_resp_valid"},   32'(ic_resp_valid),   32'd0);
        check({tag, "_dc_resp_valid"},   32'(dc_resp_valid),   32'd0);
        check({tag, "_dc_wdata_ready"},  32'(dc_wdata_ready),  32'd0);
        check({tag, "_mem_req_valid"},   32'(mem_req_valid),   32'd0);
        check({tag, "_mem_wdata_valid"}, 32'(mem_wdata_valid), 32'd0);
    endtask

    // Grant in the current (IDLE) cycle, address phase, then four read beats
    task automatic run_read(input logic exp_dc, input logic [31:0] exp_addr,
                            input logic [31:0] base, input string tag);
        #1;
        check({tag, "_grant_ic"}, 32'(ic_req_ready), 32'(!exp_dc));
        check({tag, "_grant_dc"}, 32'(dc_req_ready), 32'(exp_dc));
        tick();
        check({tag, "_addr_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, "_addr"},       mem_req_addr,       exp_addr);
        check({tag, "_rw"},         32'(mem_req_rw),    32'd0);
        check({tag, "_no_ic_rdy"},  32'(ic_req_ready),  32'd0);
        check({tag, "_no_dc_rdy"},  32'(dc_req_ready),  32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(i);
            #1;
            check({tag, "_ic_resp"}, 32'(ic_resp_valid), 32'(!exp_dc));
            check({tag, "_dc_resp"}, 32'(dc_resp_valid), 32'(exp_dc));
            check({tag, "_data"},    resp_data,          base + 32'(i));
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    logic [2:0] tie_exp;
    int         hs;
    int         wbeat;
    logic [5:0] wr_pat;

    initial begin
        reset = 1'b0;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0;
        dc_wdata_valid = 1'b0; dc_wdata = '0;
        mem_req_ready = 1'b0; mem_wdata_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;

        // Reset state; a request during reset is not accepted
        tick();
        tick();
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1000;
        #1;
        check_quiet("rst");
        check("rst_addr", mem_req_addr,     32'd0);
        check("rst_rw",   32'(mem_req_rw),  32'd0);

        // Icache read 0x1000, beats 0xA0..0xA3
        tick();
        reset = 1'b1;
        run_read(1'b0, 32'h0000_1000, 32'h0000_00A0, "ic");
        ic_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        check("ic_idle_resp_ignored", 32'(ic_resp_valid), 32'd0);
        check("ic_idle_no_addr",      32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b0;

        // Dcache writeback 0x2000, write-ready toggling
        dc_req_valid    = 1'b1;
        dc_req_rw       = 1'b1;
        dc_req_addr     = 32'h0000_2000;
        dc_wdata_valid  = 1'b1;
        dc_wdata        = 32'h0000_00B0;
        mem_wdata_ready = 1'b1;
        #1;
        check("wb_grant",       32'(dc_req_ready),   32'd1);
        check("wb_idle_no_wrdy", 32'(dc_wdata_ready), 32'd0);
        tick();
        dc_req_valid = 1'b0;
        check("wb_addr_valid", 32'(mem_req_valid),  32'd1);
        check("wb_addr",       mem_req_addr,        32'h0000_2000);
        check("wb_rw",         32'(mem_req_rw),     32'd1);
        check("wb_addr_no_wrdy", 32'(dc_wdata_ready), 32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        wr_pat = 6'b101101;   // LSB first: 1,0,1,1,0,1 -> four handshakes
        hs     = 0;
        wbeat  = 0;
        for (int c = 0; c < 6; c++) begin
            mem_wdata_ready = wr_pat[c];
            dc_wdata        = 32'h0000_00B0 + 32'(wbeat);
            #1;
            check("wb_wvalid", 32'(mem_wdata_valid), 32'd1);
            check("wb_wdata",  mem_wdata,            32'h0000_00B0 + 32'(wbeat));
            check("wb_wready", 32'(dc_wdata_ready),  32'(wr_pat[c]));
            if (dc_wdata_ready === 1'b1) begin
                hs++;
                wbeat++;
            end
            tick();
        end
        mem_wdata_ready = 1'b1;
        dc_wdata        = 32'h0000_00EE;
        #1;
        check("wb_handshakes",  32'(hs),              32'd4);
        check("wb_idle_no_wrdy2", 32'(dc_wdata_ready), 32'd0);
        check("wb_idle_no_wval",  32'(mem_wdata_valid), 32'd0);
        check("wb_idle_no_addr",  32'(mem_req_valid),   32'd0);
        dc_wdata_valid  = 1'b0;
        mem_wdata_ready = 1'b0;
        dc_req_rw       = 1'b0;

        // Simultaneous requests from reset, three rounds
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_exp = 3'b101;
`else
        tie_exp = 3'b111;
`endif
        reset = 1'b0;
        tick();
        reset        = 1'b1;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_3000;
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_4000;
        for (int k = 0; k < 3; k++) begin
            run_read(tie_exp[2-k],
                     tie_exp[2-k] ? 32'h0000_4000 : 32'h0000_3000,
                     tie_exp[2-k] ? 32'h0000_00C0 : 32'h0000_00D0,
                     "tie");
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;

        // Reset after two beats of an icache read aborts it
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_5000;
        tick();
        ic_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h0000_00E0 + 32'(i);
            #1;
            check("abort_pre_beat", 32'(ic_resp_valid), 32'd1);
            tick();
        end
        reset          = 1'b0;
        mem_resp_data  = 32'h0000_00E2;
        tick();
        #1;
        check_quiet("abort_rst");
        check("abort_addr", mem_req_addr, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_no_fwd",  32'(ic_resp_valid), 32'd0);
        check("abort_no_addr", 32'(mem_req_valid), 32'd0);
        tick();
        check("abort_no_fwd2", 32'(ic_resp_valid), 32'd0);
        mem_resp_valid = 1'b0;

        // Address phase stalled 5 cycles with a competing icache request
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b0;
        dc_req_addr  = 32'h0000_6000;
        #1;
        check("stall_grant", 32'(dc_req_ready), 32'd1);
        tick();
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_7000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_valid", 32'(mem_req_valid), 32'd1);
            check("stall_addr",  mem_req_addr,       32'h0000_6000);
            check("stall_ic_rdy", 32'(ic_req_ready), 32'd0);
            check("stall_dc_rdy", 32'(dc_req_ready), 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h0000_0F00 + 32'(i);
            #1;
            check("stall_dc_resp", 32'(dc_resp_valid), 32'd1);
            check("stall_ic_resp", 32'(ic_resp_valid), 32'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        #1;
        check("stall_next_grant", 32'(ic_req_ready), 32'd1);
        ic_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
